// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: compares the last PAT_W sampled bits
// against a loadable pattern and reports matches as a pulse plus a saturating count.
module seq_detector_prog #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W  = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  fill_state_e       state_q, state_d;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    out_d  = 1'b0;

    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      hist_d = {hist_q[PAT_W-2:0], in};
      fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      // The fill check stops a cleared history from matching an all-zero pattern.
      if ((hist_d == pat_q) && (fill_d == FULL)) begin
        out_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (!overlap) fill_d = '0;
      end
    end

    state_d = (fill_d == FULL) ? ARMED : FILLING;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      state_q <= FILLING;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      state_q <= state_d;
    end
  end

  assign out       = out_q;
  assign armed     = (state_q == ARMED);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomized and directed bench for seq_detector_prog against a queue-based
// reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst, en, din, load, ovl;
  logic [2:0] pat_in;
  logic       out_a, armed_a, out_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the sampled bits since the last clear (oldest first),
  // the active pattern, an unbounded match count and the expected pulse.
  bit       q[$];
  bit [2:0] pat_m;
  int       cnt_m;
  bit       out_m;

  always #5 clk = ~clk;

  seq_detector_prog dut_a (
    .clk(clk), .rst(rst), .in(din), .en(en), .load(load), .pat_in(pat_in),
    .overlap(ovl), .out(out_a), .armed(armed_a), .match_cnt(cnt_a)
  );

  seq_detector_prog #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(din), .en(en), .load(load), .pat_in(pat_in),
    .overlap(ovl), .out(out_b), .armed(armed_b), .match_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit window_hits();
    if (q.size() != 3) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (q[i] != pat_m[2-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, then compare all outputs at the next falling edge.
  task automatic step(input bit r, input bit e, input bit b, input bit l,
                      input logic [2:0] p, input bit o);
    rst = r; en = e; din = b; load = l; pat_in = p; ovl = o;
    @(posedge clk);
    out_m = 1'b0;
    if (r) begin
      pat_m = 3'b101; q.delete(); cnt_m = 0;
    end else if (l) begin
      pat_m = p; q.delete(); cnt_m = 0;
    end else if (e) begin
      q.push_back(b);
      if (q.size() > 3) void'(q.pop_front());
      if (window_hits()) begin
        out_m = 1'b1;
        cnt_m++;
        if (!o) q.delete();
      end
    end
    @(negedge clk);
    check("out",     32'(out_a),   32'(out_m));
    check("armed",   32'(armed_a), 32'(q.size() == 3));
    check("cnt",     32'(cnt_a),   32'(sat(cnt_m, 255)));
    check("cnt_sat", 32'(cnt_b),   32'(sat(cnt_m, 3)));
    check("out_b",   32'(out_b),   32'(out_m));
  endtask

  task automatic bit_in(input bit b, input bit o);
    step(1'b0, 1'b1, b, 1'b0, 3'b000, o);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    bit [4:0] seq5;
    bit [5:0] seq6;
    rst = 1'b1; en = 1'b0; din = 1'b0; load = 1'b0; pat_in = '0; ovl = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);

    // Overlapping detection of 101 in 10101
    seq5 = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      bit_in(seq5[i], 1'b1);
      if (i == 2) check("ovl_b3", 32'(out_a), 32'd1);
      if (i == 2) check("ovl_arm3", 32'(armed_a), 32'd1);
      if (i == 0) check("ovl_b5", 32'(out_a), 32'd1);
    end
    check("ovl_cnt", 32'(cnt_a), 32'd2);

    // Non-overlapping: only one match, history refilling afterwards
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      bit_in(seq5[i], 1'b0);
      if (i == 0) check("novl_b5", 32'(out_a), 32'd0);
    end
    check("novl_cnt", 32'(cnt_a), 32'd1);
    check("novl_arm", 32'(armed_a), 32'd0);

    // en=0 gap between bits holds state and keeps out low
    do_reset();
    bit_in(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
      check("gap_out", 32'(out_a), 32'd0);
    end
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    check("gap_hit", 32'(out_a), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    check("gap_single", 32'(out_a), 32'd0);

    // load with en: the concurrent bit is discarded
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b1);
    check("load_cnt", 32'(cnt_a), 32'd0);
    seq6 = 6'b110110;
    for (int i = 5; i >= 0; i--) bit_in(seq6[i], 1'b1);
    check("load_cnt2", 32'(cnt_a), 32'd2);

    // Saturation of the narrow counter over six overlapping matches
    do_reset();
    bit_in(1'b1, 1'b1);
    for (int m = 0; m < 6; m++) begin
      bit_in(1'b0, 1'b1);
      bit_in(1'b1, 1'b1);
    end
    check("sat_b", 32'(cnt_b), 32'd3);
    check("sat_a", 32'(cnt_a), 32'd6);

    // Reset mid-stream discards the partial match and restores the default pattern
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    do_reset();
    bit_in(1'b1, 1'b1);
    check("midrst_out", 32'(out_a), 32'd0);
    check("midrst_cnt", 32'(cnt_a), 32'd0);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    check("midrst_pat", 32'(out_a), 32'd1);

    // All-zero pattern needs three real samples
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
    bit_in(1'b0, 1'b1);
    check("zero_b1", 32'(out_a), 32'd0);
    bit_in(1'b0, 1'b1);
    check("zero_b2", 32'(out_a), 32'd0);
    bit_in(1'b0, 1'b1);
    check("zero_b3", 32'(out_a), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, e, l;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, 1'($urandom), l, 3'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
